// File: rtl/gpu_mem_pkg.sv
// Shared types and sizes for the GPU frame-SRAM access path.
package gpu_mem_pkg;

  localparam int SRAM_ADDR_W    = 24;
  localparam int SRAM_DATA_W    = 1536;
  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_ACC_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic             found;
  logic             hit;
  logic [IDX_W-1:0] cand;

  // Scan rr_ptr+1 .. rr_ptr+N; the last candidate is rr_ptr itself.
  always_comb begin
    pick     = {N{1'b0}};
    pick_idx = {IDX_W{1'b0}};
    found    = 1'b0;
    hit      = 1'b0;
    cand     = {IDX_W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand     = IDX_W'((int'(rr_ptr) + k) % N);
      hit      = ~found & req[cand];
      pick     = hit ? (pick | (N'(1) << cand)) : pick;
      pick_idx = hit ? cand : pick_idx;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin owner of the single frame-SRAM port, one access in flight,
// with an optional lock that chains a read-modify-write pair without re-arbitration.
module sram_access_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int ACC_CYCLES = ARB_ACC_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      read_enable,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               re_q, re_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;

  logic [NUM_REQ-1:0] pick_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick_s),
    .pick_idx (pick_idx_s)
  );

  // A locked continuation reloads from the current owner, otherwise from the new pick.
  assign sel_idx_s = (state_q == DONE) ? idx_q : pick_idx_s;

  // Next-state and next-output logic; SRAM pins are registered from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    ack_d    = {NUM_REQ{1'b0}};
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = ACCESS;
          gnt_d    = pick_s;
          idx_d    = pick_idx_s;
          rr_ptr_d = pick_idx_s;
          cnt_d    = 4'd0;
          we_d     = req_we[sel_idx_s];
          addr_d   = addr_arr[sel_idx_s];
          wdata_d  = wdata_arr[sel_idx_s];
        end else begin
          gnt_d = {NUM_REQ{1'b0}};
        end
      end
      ACCESS: begin
        if (cnt_q == 4'(ACC_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          ack_d   = gnt_q;
          rdata_d = we_q ? rdata_q : read_data;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (req[idx_q] & req_lock[idx_q]) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
          we_d    = req_we[sel_idx_s];
          addr_d  = addr_arr[sel_idx_s];
          wdata_d = wdata_arr[sel_idx_s];
        end else begin
          state_d = IDLE;
          gnt_d   = {NUM_REQ{1'b0}};
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
      end
    endcase

    if (state_d == ACCESS) begin
      re_d         = ~we_d;
      wr_d         = we_d;
      address_d    = addr_d;
      write_data_d = we_d ? wdata_d : {DATA_W{1'b0}};
    end else begin
      re_d         = 1'b0;
      wr_d         = 1'b0;
      address_d    = {ADDR_W{1'b0}};
      write_data_d = {DATA_W{1'b0}};
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      idx_q        <= {IDX_W{1'b0}};
      gnt_q        <= {NUM_REQ{1'b0}};
      ack_q        <= {NUM_REQ{1'b0}};
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      re_q         <= 1'b0;
      wr_q         <= 1'b0;
      address_q    <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      idx_q        <= idx_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      re_q         <= re_d;
      wr_q         <= wr_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign read_enable  = re_q;
  assign write_enable = wr_q;
  assign address      = address_q;
  assign write_data   = write_data_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: transaction-level reference model checked
// every cycle, plus hand-computed expectations for latency, ordering and data.
module tb_sram_access_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 24;
  localparam int DW  = 1536;
  localparam int ACC = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0, req_we = '0, req_lock = '0;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt, ack;
  logic [DW-1:0]     rdata, write_data;
  logic              busy, read_enable, write_enable;
  logic [AW-1:0]     address;
  logic [DW-1:0]     read_data = '0;

  logic [AW-1:0]     t_addr  [NR];
  logic [DW-1:0]     t_wdata [NR];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = t_addr[i];
      req_wdata[i*DW +: DW] = t_wdata[i];
    end
  end

  sram_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .busy(busy), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    return {64{a ^ 24'hA5C3F0}};
  endfunction

  // SRAM behaviour: unwritten words hold the preload pattern.
  logic [DW-1:0] sram [logic [AW-1:0]];
  initial forever begin
    @(negedge clk);
    if (write_enable) sram[address] = write_data;
    if (read_enable) read_data = sram.exists(address) ? sram[address] : pre(address);
    else             read_data = '0;
  end

  // Reference model: owner, cycles of enable left, latched request, committed memory.
  logic [DW-1:0] refm [logic [AW-1:0]];
  int            m_owner = -1;
  int            m_left  = 0;
  int            m_rr    = NR - 1;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [NR-1:0] m_ack   = '0;

  task automatic m_load(input int i);
    m_we    = req_we[i];
    m_addr  = t_addr[i];
    m_wdata = t_wdata[i];
    m_left  = ACC;
  endtask

  initial forever begin
    @(posedge clk);
    m_ack = '0;
    if (rst) begin
      m_owner = -1; m_left = 0; m_rr = NR - 1; m_rdata = '0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_rr + k) % NR;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_rr = m_owner;
        m_load(m_owner);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ack[m_owner] = 1'b1;
        if (m_we) refm[m_addr] = m_wdata;
        else      m_rdata = refm.exists(m_addr) ? refm[m_addr] : pre(m_addr);
      end
    end else if (req[m_owner] && req_lock[m_owner]) begin
      m_load(m_owner);
    end else begin
      m_owner = -1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (low 96 bits) at %0t", nm, act[95:0], exp[95:0], $time);
    end
  endtask

  // Per-cycle comparison against the reference model and the invariants.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [NR-1:0] e_gnt;
      bit act_s;
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      act_s = (m_owner >= 0) && (m_left > 0);
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("ack", 64'(ack), 64'(m_ack));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      chk("read_enable", 64'(read_enable), 64'(act_s && !m_we));
      chk("write_enable", 64'(write_enable), 64'(act_s && m_we));
      chk("address", 64'(address), act_s ? 64'(m_addr) : 64'd0);
      chkw("write_data", write_data, (act_s && m_we) ? m_wdata : '0);
      chkw("rdata", rdata, m_rdata);
      chk("inv_both_en", 64'(read_enable & write_enable), 64'd0);
      chk("inv_onehot", 64'($onehot0(gnt)), 64'd1);
      chk("inv_ack_gnt", 64'(ack & ~gnt), 64'd0);
    end
  end

  task automatic set_req(input int i, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; req_we[i] = we; req_lock[i] = lk; t_addr[i] = a; t_wdata[i] = d;
  endtask

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    int re_cnt, ack_at, nacks, a1;
    int seq [$];
    logic [DW-1:0] w5;
    for (int i = 0; i < NR; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_en", 64'({read_enable, write_enable}), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chkw("rst_rdata", rdata, '0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset in the middle of a write aborts it with no ack.
    set_req(1, 1'b1, 1'b0, 24'h000030, {64{24'h0BADF0}});
    @(negedge clk);
    chk("t1_we_high", 64'(write_enable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_we_low", 64'(write_enable), 64'd0);
    chk("t1_gnt", 64'(gnt), 64'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= ack[1]; end
    chk("t1_no_ack", 64'(seen), 64'd0);

    // Single read: enable high ACC(=3) cycles, ack at offset ACC+1(=4).
    set_req(2, 1'b0, 1'b0, 24'h000100, '0);
    re_cnt = 0; ack_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req[2] = 1'b0;
      re_cnt += int'(read_enable);
      if (ack[2] && ack_at == 0) begin
        ack_at = k;
        chkw("t2_rdata", rdata, {64{24'hA5C2F0}});
      end
    end
    chk("t2_re_cycles", 64'(re_cnt), 64'd3);
    chk("t2_ack_at", 64'(ack_at), 64'd4);

    // Write then read back the same word.
    set_req(1, 1'b1, 1'b0, 24'h000010, {64{24'hFFEEDD}});
    seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req[1] = 1'b0;
      seen |= ack[1];
    end
    chk("t3_wr_ack", 64'(seen), 64'd1);
    set_req(0, 1'b0, 1'b0, 24'h000010, '0);
    seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req[0] = 1'b0;
      if (ack[0]) begin
        seen = 1'b1;
        chkw("t3_rdata", rdata, {64{24'hFFEEDD}});
      end
    end
    chk("t3_rd_ack", 64'(seen), 64'd1);

    // All four held, no lock: grants rotate 0,1,2,3,... one every ACC+2 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 24'h000040 + 24'(i), '0);
    nacks = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack != '0) begin
        chk("t4_order", 64'(idx_of(ack)), 64'(nacks % 4));
        nacks++;
      end
    end
    req = '0;
    chk("t4_count", 64'(nacks), 64'd8);
    repeat (8) @(negedge clk);

    // Locked read-modify-write on requester 3 while requester 0 waits.
    w5 = {64{24'h123456}};
    set_req(3, 1'b0, 1'b1, 24'h000020, '0);
    a1 = 0; seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        set_req(0, 1'b0, 1'b0, 24'h000020, '0);
        req_we[3] = 1'b1; t_wdata[3] = w5;
      end
      if (a1 != 0 && k == a1 + 1) req_lock[3] = 1'b0;
      if (gnt[0] && seq.size() < 2) seen = 1'b1;
      if (ack != '0) begin
        seq.push_back(idx_of(ack));
        if (seq.size() == 1) begin
          a1 = k;
          chkw("t5_rd_data", rdata, {64{24'hA5C3D0}});
        end
        if (seq.size() == 2) req[3] = 1'b0;
        if (seq.size() == 3) begin
          req[0] = 1'b0;
          chkw("t5_rmw_result", rdata, w5);
        end
      end
    end
    chk("t5_n_acks", 64'(seq.size()), 64'd3);
    if (seq.size() == 3) begin
      chk("t5_seq0", 64'(seq[0]), 64'd3);
      chk("t5_seq1", 64'(seq[1]), 64'd3);
      chk("t5_seq2", 64'(seq[2]), 64'd0);
    end
    chk("t5_no_early_gnt0", 64'(seen), 64'd0);

    // Requester drops its request mid-access: the access still completes.
    set_req(1, 1'b0, 1'b0, 24'h000044, '0);
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) req[1] = 1'b0;
      if (ack[1]) begin
        seen = 1'b1;
        chkw("t6_rdata", rdata, {64{24'hA5C3B4}});
      end
    end
    chk("t6_ack", 64'(seen), 64'd1);
    chk("t6_idle", 64'(busy), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
